// File: rtl/vec_alu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vec_alu_pkg : shared ALU opcode, flag index and sequencer state types
// Revision    : 1.0
// ---------------------------------------------------------------------------
package vec_alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_MUL = 2'b10,
    ALU_DIV = 2'b11
  } alu_op_e;

  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/vector_alu_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vector_alu_sequencer : lane-serial issuer feeding an external scalar ALU
// Revision             : 1.0
// ---------------------------------------------------------------------------
module vector_alu_sequencer
  import vec_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LANES = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start_valid,
  output logic                     o_start_ready,
  input  logic [1:0]               i_op,
  input  logic [WIDTH*LANES-1:0]   i_vec_a,
  input  logic [WIDTH*LANES-1:0]   i_vec_b,
  output logic [WIDTH-1:0]         o_alu_in0,
  output logic [WIDTH-1:0]         o_alu_in1,
  output logic [1:0]               o_alu_op,
  input  logic [WIDTH-1:0]         i_alu_out,
  input  logic [1:0]               i_alu_flags,
  output logic                     o_done_valid,
  input  logic                     i_done_ready,
  output logic [WIDTH*LANES-1:0]   o_vec_res,
  output logic                     o_zero_all,
  output logic                     o_neg_any,
  output logic                     o_div_zero
);

  localparam int              CW     = $clog2(LANES);
  localparam logic [CW-1:0]   c_LAST = CW'(LANES - 1);

  seq_state_e                 r_state;
  alu_op_e                    r_op;
  logic [WIDTH*LANES-1:0]     r_a;
  logic [WIDTH*LANES-1:0]     r_b;
  logic [WIDTH*LANES-1:0]     r_res;
  logic [CW-1:0]              r_lane;
  logic                       r_zero_all;
  logic                       r_neg_any;
  logic                       r_div_zero;
  logic                       r_start_ready;
  logic                       r_done_valid;

  logic [WIDTH-1:0]           w_a_lane;
  logic [WIDTH-1:0]           w_b_lane;
  logic                       w_issue;
  logic                       w_dz;

  assign w_a_lane = r_a[int'(r_lane)*WIDTH +: WIDTH];
  assign w_b_lane = r_b[int'(r_lane)*WIDTH +: WIDTH];
  assign w_issue  = (r_state == ISSUE);
  assign w_dz     = (r_op == ALU_DIV) && (w_b_lane == '0);

  // A zero divisor is replaced by 1 so the ALU never sees a divide by zero.
  assign o_alu_in0 = w_issue ? w_a_lane : '0;
  assign o_alu_in1 = w_issue ? (w_dz ? WIDTH'(1) : w_b_lane) : '0;
  assign o_alu_op  = w_issue ? 2'(r_op) : 2'b00;

  assign o_start_ready = r_start_ready;
  assign o_done_valid  = r_done_valid;
  assign o_vec_res     = r_res;
  assign o_zero_all    = r_zero_all;
  assign o_neg_any     = r_neg_any;
  assign o_div_zero    = r_div_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_op          <= ALU_ADD;
      r_a           <= '0;
      r_b           <= '0;
      r_res         <= '0;
      r_lane        <= '0;
      r_zero_all    <= 1'b0;
      r_neg_any     <= 1'b0;
      r_div_zero    <= 1'b0;
      r_start_ready <= 1'b1;
      r_done_valid  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start_valid) begin
            r_op          <= alu_op_e'(i_op);
            r_a           <= i_vec_a;
            r_b           <= i_vec_b;
            r_res         <= '0;
            r_zero_all    <= 1'b1;
            r_neg_any     <= 1'b0;
            r_div_zero    <= 1'b0;
            r_lane        <= '0;
            r_start_ready <= 1'b0;
            r_state       <= ISSUE;
          end
        end
        ISSUE: begin
          // Divide-by-zero lanes read as 0 with Z=1, N=0 regardless of the ALU.
          r_res[int'(r_lane)*WIDTH +: WIDTH] <= w_dz ? '0 : i_alu_out;
          r_zero_all <= r_zero_all & (w_dz | i_alu_flags[FLAG_Z]);
          r_neg_any  <= r_neg_any | (~w_dz & i_alu_flags[FLAG_N]);
          if (w_dz) begin
            r_div_zero <= 1'b1;
          end
          if (r_lane == c_LAST) begin
            r_done_valid <= 1'b1;
            r_state      <= DONE;
          end else begin
            r_lane <= r_lane + CW'(1);
          end
        end
        DONE: begin
          if (i_done_ready) begin
            r_done_valid  <= 1'b0;
            r_start_ready <= 1'b1;
            r_state       <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
